// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared processor definitions used by the program-counter sequencer and its
//   return-address stack: default PC width, stack depth, reset vector and the
//   next-PC select encoding.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    // Default width of the PC and every instruction-address port.
    localparam int PC_WIDTH_DEF  = 8;

    // Default number of return-address stack entries (power of two, >= 2).
    localparam int RAS_DEPTH_DEF = 4;

    // Reset vector; also the redirect target when a Return finds the stack empty.
    localparam int RESET_PC_DEF  = 0;

    // Next-PC source select.
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,  // PC + 1
        SEL_BRANCH = 2'd1,  // BranchTarget from the branch formatter
        SEL_RETURN = 2'd2   // top of the return-address stack
    } nextSel_t;

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
//   Circular LIFO holding return addresses for call/return pairs.
//   A push onto a full stack overwrites the oldest entry and keeps the count
//   saturated at DEPTH. A pop on an empty stack changes nothing and only raises
//   the underflow flag.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; clears pointer and count
//   push       in   write pushData above the current top
//   pop        in   discard the current top (ignored when empty)
//   pushData   in   WIDTH   return address to store
//   topData    out  WIDTH   current top entry (don't-care when count is 0)
//   count      out  number of valid entries, 0..DEPTH
//   overflow   out  combinational: push while full
//   underflow  out  combinational: pop while empty
//
// push and pop are never asserted together by the sequencer; if they were,
// push would take precedence.
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         pushData,
    output logic [WIDTH-1:0]         topData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] topPtr;
    logic [PTR_W-1:0] pushPtr;
    logic             full;
    logic             empty;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally. When the
    // stack is full the slot just above the top is the oldest entry, which is
    // exactly the one a push should overwrite.
    assign pushPtr   = topPtr + PTR_W'(1);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    assign topData   = entries[topPtr];
    assign overflow  = push && full;
    assign underflow = pop && !push && empty;

    // Control: pointer and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            topPtr <= '0;
            count  <= '0;
        end else if (push) begin
            topPtr <= pushPtr;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            topPtr <= topPtr - PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

    // Data: entry storage carries no reset; contents are only meaningful
    // while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[pushPtr] <= pushData;
        end
    end

endmodule : ras_stack

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the single-cycle core. Holds the PC, picks
//   the next PC from sequential / branch / return sources and keeps a small
//   return-address stack for call/return pairs. Drives the instruction ROM.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high; clears PC, stack and pulses
//   Stall         in   freeze PC and stack; control inputs ignored
//   BranchTaken   in   redirect to BranchTarget
//   BranchTarget  in   PC_WIDTH  resolved target from the branch formatter
//   Call          in   with BranchTaken (and no Return): push PC+1
//   Return        in   redirect to the stack top and pop
//   PC            out  PC_WIDTH  current instruction address (registered)
//   PCPlus1       out  PC_WIDTH  PC+1 modulo 2^PC_WIDTH (combinational)
//   Flush         out  registered; high while PC holds a redirected value
//   RasOverflow   out  registered pulse: push onto a full stack
//   RasUnderflow  out  registered pulse: Return with an empty stack
//
// Next-PC priority with Stall low: Return > BranchTaken > sequential.
// All redirects take effect one cycle after the sampling edge; Flush and the
// stack pulses appear in the same cycle as the new PC.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH  = PC_WIDTH_DEF,
    parameter int                  RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    input  logic                Call,
    input  logic                Return,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PCPlus1,
    output logic                Flush,
    output logic                RasOverflow,
    output logic                RasUnderflow
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    nextSel_t              nextSel;
    logic [PC_WIDTH-1:0]   nextPc;
    logic                  rasPush;
    logic                  rasPop;
    logic [PC_WIDTH-1:0]   rasTop;
    logic [CNT_W-1:0]      rasCount;
    logic                  rasOverflow;
    logic                  rasUnderflow;

    assign PCPlus1 = PC + PC_WIDTH'(1);

    // Source select. Stall suppresses every control input, so a stalled cycle
    // looks like a sequential one to the stack (no push, no pop).
    always_comb begin
        nextSel = SEL_SEQ;
        if (!Stall) begin
            if (Return) begin
                nextSel = SEL_RETURN;
            end else if (BranchTaken) begin
                nextSel = SEL_BRANCH;
            end
        end
    end

    // Call only counts when it qualifies a taken branch that Return has not
    // overridden, which is exactly the SEL_BRANCH case.
    assign rasPush = (nextSel == SEL_BRANCH) && Call;
    assign rasPop  = (nextSel == SEL_RETURN);

    // Return with an empty stack falls back to the reset vector.
    always_comb begin
        nextPc = PCPlus1;
        case (nextSel)
            SEL_RETURN: nextPc = (rasCount == '0) ? RESET_PC : rasTop;
            SEL_BRANCH: nextPc = BranchTarget;
            default:    nextPc = PCPlus1;
        endcase
    end

    ras_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (rasPush),
        .pop       (rasPop),
        .pushData  (PCPlus1),
        .topData   (rasTop),
        .count     (rasCount),
        .overflow  (rasOverflow),
        .underflow (rasUnderflow)
    );

    // PC register and the pulses that accompany a newly loaded PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC           <= RESET_PC;
            Flush        <= 1'b0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else if (Stall) begin
            Flush        <= 1'b0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else begin
            PC           <= nextPc;
            Flush        <= (nextSel != SEL_SEQ);
            RasOverflow  <= rasOverflow;
            RasUnderflow <= rasUnderflow;
        end
    end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed testbench for pc_sequencer (PC_WIDTH=8, RAS_DEPTH=4, RESET_PC=0).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, one unit after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Stall = 1'b0;
    logic       BranchTaken = 1'b0;
    logic [7:0] BranchTarget = 8'h00;
    logic       Call = 1'b0;
    logic       Return = 1'b0;
    logic [7:0] PC;
    logic [7:0] PCPlus1;
    logic       Flush;
    logic       RasOverflow;
    logic       RasUnderflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_WIDTH  (8),
        .RAS_DEPTH (4),
        .RESET_PC  (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Call         (Call),
        .Return       (Return),
        .PC           (PC),
        .PCPlus1      (PCPlus1),
        .Flush        (Flush),
        .RasOverflow  (RasOverflow),
        .RasUnderflow (RasUnderflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCtl(input logic st, input logic bt, input logic cl,
                          input logic rt, input logic [7:0] tgt);
        Stall        = st;
        BranchTaken  = bt;
        Call         = cl;
        Return       = rt;
        BranchTarget = tgt;
    endtask

    task automatic applyReset();
        setCtl(0, 0, 0, 0, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        setCtl(0, 0, 0, 0, 8'h00);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", PC); end
        checks++;
        if ({Flush, RasOverflow, RasUnderflow} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {Flush, RasOverflow, RasUnderflow});
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (PC !== 8'(i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, 8'(i)); end
            checks++;
            if (PCPlus1 !== 8'(i + 1)) begin errors++; $display("FAIL seq_pcplus1[%0d]: got %h want %h", i, PCPlus1, 8'(i + 1)); end
            checks++;
            if (Flush !== 1'b0) begin errors++; $display("FAIL seq_flush[%0d]: got %b want 0", i, Flush); end
        end
    endtask

    task automatic test_wrap();
        setCtl(0, 1, 0, 0, 8'hFE);
        tick();
        checks++;
        if ({PC, Flush} !== {8'hFE, 1'b1}) begin errors++; $display("FAIL wrap_branch: got %h/%b want fe/1", PC, Flush); end
        setCtl(0, 0, 0, 0, 8'h00);
        tick();
        checks++;
        if ({PC, PCPlus1, Flush} !== {8'hFF, 8'h00, 1'b0}) begin
            errors++; $display("FAIL wrap_ff: got %h/%h/%b want ff/00/0", PC, PCPlus1, Flush);
        end
        tick();
        checks++;
        if ({PC, PCPlus1, Flush} !== {8'h00, 8'h01, 1'b0}) begin
            errors++; $display("FAIL wrap_00: got %h/%h/%b want 00/01/0", PC, PCPlus1, Flush);
        end
    endtask

    task automatic test_call_return();
        applyReset();
        setCtl(0, 1, 0, 0, 8'h10);
        tick();
        setCtl(0, 1, 1, 0, 8'h40);
        tick();
        checks++;
        if ({PC, Flush} !== {8'h40, 1'b1}) begin errors++; $display("FAIL call_pc: got %h/%b want 40/1", PC, Flush); end
        setCtl(0, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({PC, Flush} !== {8'(8'h40 + i), 1'b0}) begin
                errors++; $display("FAIL call_seq[%0d]: got %h/%b want %h/0", i, PC, Flush, 8'(8'h40 + i));
            end
        end
        setCtl(0, 0, 0, 1, 8'h00);
        tick();
        checks++;
        if ({PC, Flush, RasUnderflow} !== {8'h11, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ret_pc: got %h/%b/%b want 11/1/0", PC, Flush, RasUnderflow);
        end
        // Stack must now be empty: the next Return underflows to the reset vector.
        tick();
        checks++;
        if ({PC, Flush, RasUnderflow} !== {8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ret_empty: got %h/%b/%b want 00/1/1", PC, Flush, RasUnderflow);
        end
        setCtl(0, 0, 0, 0, 8'h00);
        tick();
        checks++;
        if ({PC, Flush, RasUnderflow} !== {8'h01, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ret_after: got %h/%b/%b want 01/0/0", PC, Flush, RasUnderflow);
        end
    endtask

    task automatic test_stall();
        applyReset();
        setCtl(0, 1, 0, 0, 8'h20);
        tick();
        setCtl(1, 1, 1, 0, 8'h80);
        tick();
        checks++;
        if ({PC, Flush} !== {8'h20, 1'b0}) begin errors++; $display("FAIL stall_hold1: got %h/%b want 20/0", PC, Flush); end
        tick();
        checks++;
        if ({PC, PCPlus1, Flush} !== {8'h20, 8'h21, 1'b0}) begin
            errors++; $display("FAIL stall_hold2: got %h/%h/%b want 20/21/0", PC, PCPlus1, Flush);
        end
        setCtl(0, 0, 0, 0, 8'h00);
        tick();
        checks++;
        if ({PC, Flush} !== {8'h21, 1'b0}) begin errors++; $display("FAIL stall_resume: got %h/%b want 21/0", PC, Flush); end
        // The stalled Call must not have pushed anything.
        setCtl(0, 0, 0, 1, 8'h00);
        tick();
        checks++;
        if ({PC, RasUnderflow} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL stall_ras: got %h/%b want 00/1", PC, RasUnderflow);
        end
        // A stall right after a pulse clears it.
        setCtl(1, 0, 0, 1, 8'h00);
        tick();
        checks++;
        if ({PC, Flush, RasUnderflow} !== {8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL stall_clear: got %h/%b/%b want 00/0/0", PC, Flush, RasUnderflow);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] retPc [4];
        retPc[0] = 8'h41; retPc[1] = 8'h31; retPc[2] = 8'h21; retPc[3] = 8'h11;
        applyReset();
        for (int k = 0; k < 5; k++) begin
            setCtl(0, 1, 1, 0, 8'((k + 1) * 16));
            tick();
            checks++;
            if ({PC, Flush, RasOverflow} !== {8'((k + 1) * 16), 1'b1, (k == 4)}) begin
                errors++; $display("FAIL ovf_call[%0d]: got %h/%b/%b want %h/1/%b",
                                   k, PC, Flush, RasOverflow, 8'((k + 1) * 16), (k == 4));
            end
        end
        setCtl(0, 0, 0, 1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({PC, Flush, RasOverflow, RasUnderflow} !== {retPc[k], 1'b1, 1'b0, 1'b0}) begin
                errors++; $display("FAIL ovf_ret[%0d]: got %h/%b/%b/%b want %h/1/0/0",
                                   k, PC, Flush, RasOverflow, RasUnderflow, retPc[k]);
            end
        end
        tick();
        checks++;
        if ({PC, Flush, RasUnderflow} !== {8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf_underflow: got %h/%b/%b want 00/1/1", PC, Flush, RasUnderflow);
        end
        setCtl(0, 0, 0, 0, 8'h00);
        tick();
        checks++;
        if ({PC, Flush, RasUnderflow} !== {8'h01, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ovf_after: got %h/%b/%b want 01/0/0", PC, Flush, RasUnderflow);
        end
    endtask

    task automatic test_combined();
        applyReset();
        setCtl(0, 1, 1, 0, 8'h32);   // push 01
        tick();
        setCtl(0, 1, 1, 0, 8'h70);   // push 33
        tick();
        checks++;
        if (PC !== 8'h70) begin errors++; $display("FAIL comb_setup: got %h want 70", PC); end
        setCtl(0, 1, 1, 1, 8'h90);
        tick();
        checks++;
        if ({PC, Flush, RasOverflow} !== {8'h33, 1'b1, 1'b0}) begin
            errors++; $display("FAIL comb_ret: got %h/%b/%b want 33/1/0", PC, Flush, RasOverflow);
        end
        setCtl(0, 0, 0, 1, 8'h00);
        tick();
        checks++;
        if ({PC, RasUnderflow} !== {8'h01, 1'b0}) begin
            errors++; $display("FAIL comb_pop: got %h/%b want 01/0", PC, RasUnderflow);
        end
        tick();
        checks++;
        if ({PC, RasUnderflow} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL comb_empty: got %h/%b want 00/1", PC, RasUnderflow);
        end
    endtask

    task automatic test_reset_priority();
        setCtl(0, 1, 0, 0, 8'h55);
        tick();
        setCtl(1, 1, 1, 1, 8'h99);
        reset = 1'b1;
        tick();
        checks++;
        if ({PC, Flush, RasOverflow, RasUnderflow} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_prio: got %h/%b/%b/%b want 00/0/0/0",
                               PC, Flush, RasOverflow, RasUnderflow);
        end
        reset = 1'b0;
        setCtl(0, 0, 0, 0, 8'h00);
        tick();
        checks++;
        if ({PC, Flush} !== {8'h01, 1'b0}) begin errors++; $display("FAIL reset_prio_after: got %h/%b want 01/0", PC, Flush); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_call_return();
        test_stall();
        test_overflow();
        test_combined();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer
